cart_mmc1: RTL and testbench

Parametrised cartridge emulator that supports the MMC1 (iNES mapper 1) banking scheme. It sits between the CPU/PPU buses and on-chip PRG/CHR memories, in the same place as the fixed-mapping cartridge. CPU writes to $8000-$FFFF are decoded into MMC1 serial register loads, which drive PRG bank switching, CHR bank switching and nametable mirroring. A load mode lets the host write ROM images into PRG memory.

---
 rtl/cart_mmc1.sv | 133 +++++++++++++
 tb/tb_cart_mmc1.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cart_mmc1.sv
// rtl/cart_mmc1.sv - MMC1 (iNES mapper 1) cartridge with serial bank registers and on-chip PRG/CHR memories
// Optional: CART_MMC1_WRITE_FILTER_EN ignores a mapper write that starts within one cycle of the previous accepted one.
module cart_mmc1 #(
  parameter int PRG_BANK_BITS = 3,
  parameter int CHR_BANK_BITS = 1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        prg_nce_in,
  input  logic [14:0] prg_a_in,
  input  logic        prg_r_nw_in,
  input  logic [7:0]  prg_d_in,
  output logic [7:0]  prg_d_out,
  input  logic        prg_ld_in,
  input  logic [13:0] chr_a_in,
  input  logic        chr_r_nw_in,
  input  logic [7:0]  chr_d_in,
  output logic [7:0]  chr_d_out,
  output logic        ciram_nce_out,
  output logic        ciram_a10_out
);
  localparam int PRG_AW = PRG_BANK_BITS + 14;
  localparam int CHR_AW = CHR_BANK_BITS + 12;
  localparam int PBW    = (PRG_BANK_BITS > 4) ? PRG_BANK_BITS : 4;
  localparam int CBW    = (CHR_BANK_BITS > 5) ? CHR_BANK_BITS : 5;

  logic [4:0]        shift, ctrl, chr0, chr1, prg;
  logic [4:0]        shift_next;
  logic              wr, wr_q, accept;
  logic [PBW-1:0]    prg_bank_full;
  logic [CBW-1:0]    chr_bank_full;
  logic [PRG_AW-1:0] prg_addr;
  logic [CHR_AW-1:0] chr_addr;
  logic [7:0]        prg_mem [0:(1<<PRG_AW)-1];
  logic [7:0]        chr_mem [0:(1<<CHR_AW)-1];
  logic [7:0]        prg_q, chr_q;
  logic              unused_bits;

  assign wr = ~prg_nce_in & ~prg_r_nw_in & ~prg_ld_in;

`ifdef CART_MMC1_WRITE_FILTER_EN
  // acc_run marks cycles of an accepted strobe; two cycles of history cover the one-idle-cycle window
  logic acc_run, acc_run_q, acc_run_q2;
  assign accept  = wr & ~wr_q & ~acc_run_q2;
  assign acc_run = accept | (wr & wr_q & acc_run_q);
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      acc_run_q  <= 1'b0;
      acc_run_q2 <= 1'b0;
    end else begin
      acc_run_q  <= acc_run;
      acc_run_q2 <= acc_run_q;
    end
  end
`else
  assign accept = wr & ~wr_q;
`endif

  assign shift_next = {prg_d_in[0], shift[4:1]};

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_q  <= 1'b0;
      shift <= 5'b10000;
      ctrl  <= 5'b01100;
      chr0  <= 5'd0;
      chr1  <= 5'd0;
      prg   <= 5'd0;
    end else begin
      wr_q <= wr;
      if (accept) begin
        if (prg_d_in[7]) begin
          shift <= 5'b10000;
          ctrl  <= ctrl | 5'b01100;
        end else if (shift[0]) begin
          // marker bit reached bit 0: this is the fifth bit, commit to the selected register
          case (prg_a_in[14:13])
            2'd0:    ctrl <= shift_next;
            2'd1:    chr0 <= shift_next;
            2'd2:    chr1 <= shift_next;
            default: prg  <= shift_next;
          endcase
          shift <= 5'b10000;
        end else begin
          shift <= shift_next;
        end
      end
    end
  end

  always_comb begin
    prg_bank_full = '0;
    case (ctrl[3:2])
      2'd2:    prg_bank_full = prg_a_in[14] ? PBW'(prg[3:0]) : '0;
      2'd3:    prg_bank_full = prg_a_in[14] ? '1 : PBW'(prg[3:0]);
      default: prg_bank_full = PBW'({prg[3:1], prg_a_in[14]});
    endcase
  end

  assign chr_bank_full = ctrl[4] ? CBW'(chr_a_in[12] ? chr1 : chr0)
                                 : CBW'({chr0[4:1], chr_a_in[12]});

  assign prg_addr = {prg_bank_full[PRG_BANK_BITS-1:0], prg_a_in[13:0]};
  assign chr_addr = {chr_bank_full[CHR_BANK_BITS-1:0], chr_a_in[11:0]};

  always_ff @(posedge clk_in) begin
    if (~prg_nce_in & ~prg_r_nw_in & prg_ld_in)
      prg_mem[prg_addr] <= prg_d_in;
    prg_q <= prg_mem[prg_addr];
  end

  always_ff @(posedge clk_in) begin
    if (~chr_a_in[13] & ~chr_r_nw_in)
      chr_mem[chr_addr] <= chr_d_in;
    chr_q <= chr_mem[chr_addr];
  end

  assign prg_d_out     = prg_nce_in ? 8'h00 : prg_q;
  assign chr_d_out     = chr_a_in[13] ? 8'h00 : chr_q;
  assign ciram_nce_out = ~chr_a_in[13];

  always_comb begin
    ciram_a10_out = 1'b0;
    case (ctrl[1:0])
      2'd0:    ciram_a10_out = 1'b0;
      2'd1:    ciram_a10_out = 1'b1;
      2'd2:    ciram_a10_out = chr_a_in[10];
      default: ciram_a10_out = chr_a_in[11];
    endcase
  end

  assign unused_bits = ^{prg[4], prg_bank_full, chr_bank_full};
endmodule

// File: tb/tb_cart_mmc1.sv
// tb/tb_cart_mmc1.sv - randomized self-checking bench for cart_mmc1 against a behavioural MMC1 model
module tb_cart_mmc1;
  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        prg_nce_in;
  logic [14:0] prg_a_in;
  logic        prg_r_nw_in;
  logic [7:0]  prg_d_in;
  logic [7:0]  prg_d_out;
  logic        prg_ld_in;
  logic [13:0] chr_a_in;
  logic        chr_r_nw_in;
  logic [7:0]  chr_d_in;
  logic [7:0]  chr_d_out;
  logic        ciram_nce_out;
  logic        ciram_a10_out;

  cart_mmc1 dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .prg_nce_in(prg_nce_in), .prg_a_in(prg_a_in), .prg_r_nw_in(prg_r_nw_in),
    .prg_d_in(prg_d_in), .prg_d_out(prg_d_out), .prg_ld_in(prg_ld_in),
    .chr_a_in(chr_a_in), .chr_r_nw_in(chr_r_nw_in), .chr_d_in(chr_d_in),
    .chr_d_out(chr_d_out), .ciram_nce_out(ciram_nce_out), .ciram_a10_out(ciram_a10_out)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;

  int m_ctrl, m_chr0, m_chr1, m_prg, m_nbits, m_acc;
  int prg_img [int];
  int chr_img [8192];
  int offs [6];

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_ctrl = 12; m_chr0 = 0; m_chr1 = 0; m_prg = 0; m_nbits = 0; m_acc = 0;
  endfunction

  // serial port as a bit counter and accumulated value, LSB first
  function automatic void model_serial(input int sel, input int d);
    if (d >= 128) begin
      m_nbits = 0; m_acc = 0; m_ctrl = m_ctrl | 12;
    end else begin
      m_acc = m_acc + ((d % 2) << m_nbits);
      m_nbits++;
      if (m_nbits == 5) begin
        case (sel)
          0: m_ctrl = m_acc;
          1: m_chr0 = m_acc;
          2: m_chr1 = m_acc;
          default: m_prg = m_acc;
        endcase
        m_nbits = 0; m_acc = 0;
      end
    end
  endfunction

  function automatic int prg_map(input int addr);
    int mode, hi, bank;
    mode = (m_ctrl / 4) % 4;
    hi   = (addr / 16384) % 2;
    if (mode < 2)       bank = (m_prg % 16) - (m_prg % 2) + hi;
    else if (mode == 2) bank = hi ? (m_prg % 16) : 0;
    else                bank = hi ? 15 : (m_prg % 16);
    return (bank % 8) * 16384 + (addr % 16384);
  endfunction

  function automatic int chr_map(input int a);
    int hi, bank;
    hi = (a / 4096) % 2;
    if ((m_ctrl / 16) % 2 == 0) bank = m_chr0 - (m_chr0 % 2) + hi;
    else                        bank = hi ? m_chr1 : m_chr0;
    return (bank % 2) * 4096 + (a % 4096);
  endfunction

  function automatic int mirror_exp(input int a);
    case (m_ctrl % 4)
      0: return 0;
      1: return 1;
      2: return (a / 1024) % 2;
      default: return (a / 2048) % 2;
    endcase
  endfunction

  task automatic cpu_write(input int addr, input int d, input int hold);
    prg_a_in = addr[14:0]; prg_d_in = d[7:0];
    prg_nce_in = 1'b0; prg_r_nw_in = 1'b0;
    for (int i = 0; i < hold; i++) step();
    prg_nce_in = 1'b1; prg_r_nw_in = 1'b1;
    step(); step();
    if (prg_ld_in) prg_img[prg_map(addr)] = d;
    else model_serial((addr / 8192) % 4, d);
  endtask

  task automatic serial_write(input int sel, input int val);
    for (int i = 0; i < 5; i++)
      cpu_write(32'h8000 + sel * 8192, (val >> i) % 2, (i == 2) ? 3 : 1);
  endtask

  task automatic cpu_read_check(input int addr, input string tag);
    int k, exp;
    k = prg_map(addr);
    exp = prg_img.exists(k) ? prg_img[k] : -1;
    prg_a_in = addr[14:0]; prg_nce_in = 1'b0; prg_r_nw_in = 1'b1;
    step();
    check(tag, int'(prg_d_out), exp);
    prg_nce_in = 1'b1;
    #1;
    check({tag, "_gate"}, int'(prg_d_out), 0);
  endtask

  task automatic ppu_write(input int a, input int d);
    chr_a_in = a[13:0]; chr_d_in = d[7:0]; chr_r_nw_in = 1'b0;
    step();
    chr_r_nw_in = 1'b1;
    if (a < 8192) chr_img[chr_map(a)] = d;
  endtask

  task automatic ppu_read_check(input int a, input string tag);
    chr_a_in = a[13:0]; chr_r_nw_in = 1'b1;
    step();
    check({tag, "_data"}, int'(chr_d_out), (a >= 8192) ? 0 : chr_img[chr_map(a)]);
    check({tag, "_nce"}, int'(ciram_nce_out), (a >= 8192) ? 0 : 1);
    check({tag, "_a10"}, int'(ciram_a10_out), mirror_exp(a));
  endtask

  initial begin
    rst_in = 1'b1; prg_nce_in = 1'b1; prg_a_in = '0; prg_r_nw_in = 1'b1;
    prg_d_in = '0; prg_ld_in = 1'b0; chr_a_in = 14'h2000; chr_r_nw_in = 1'b1; chr_d_in = '0;
    model_reset();
    step(); step();
    rst_in = 1'b0;
    step();
    check("rst_prg_gate", int'(prg_d_out), 0);
    check("rst_chr_gate", int'(chr_d_out), 0);
    check("rst_ciram_nce", int'(ciram_nce_out), 0);
    check("rst_a10", int'(ciram_a10_out), 0);

    offs[0] = 0; offs[1] = 16'h3FFC; offs[2] = 16'h3FFF;
    for (int i = 3; i < 6; i++) offs[i] = $urandom_range(1, 16'h3FFB);

    // image load through 32 KB mode, two banks per prg value
    serial_write(0, 0);
    for (int b = 0; b < 4; b++) begin
      serial_write(3, b * 2);
      prg_ld_in = 1'b1;
      for (int h = 0; h < 2; h++)
        for (int i = 0; i < 6; i++)
          cpu_write(h * 16384 + offs[i], $urandom_range(0, 255), 1);
      prg_ld_in = 1'b0;
    end
    check("load_regs_kept", m_prg, 6);
    cpu_read_check(16'h4000 + offs[1], "load_readback");

    for (int a = 0; a < 8192; a++) ppu_write(a, $urandom_range(0, 255));

    // asynchronous reset mid-sequence
    serial_write(0, 5'b01101);
    chr_a_in = 14'h2000;
    #1;
    check("mirror1_a10", int'(ciram_a10_out), 1);
    cpu_write(16'h8000, 1, 1);
    cpu_write(16'h8000, 1, 1);
    rst_in = 1'b1;
    #1;
    check("async_rst_a10", int'(ciram_a10_out), 0);
    step();
    rst_in = 1'b0;
    model_reset();
    cpu_read_check(16'hFFFC, "reset_fffc");
    check("reset_fffc_bank7", prg_img.exists(7 * 16384 + 16'h3FFC) ? 1 : 0, 1);

    serial_write(0, 5'b00110);
    check("ctrl_00110", m_ctrl, 6);
    ppu_read_check(14'h2400, "vmirror_hi");
    ppu_read_check(14'h2000, "vmirror_lo");
    ppu_read_check(14'h2800, "vmirror_a11");
    cpu_read_check(16'hC000 + offs[3], "mode1_read");

    cpu_write(16'h8000, 16'h80, 1);
    serial_write(3, 5);
    cpu_read_check(16'h8000, "mode3_bank5");
    cpu_read_check(16'hC000, "mode3_bank7");

    cpu_write(16'hA000, 1, 1);
    cpu_write(16'hA000, 0, 1);
    cpu_write(16'h8000, 16'h80, 1);
    check("reset_bit_mode3", (m_ctrl / 4) % 4, 3);
    serial_write(3, 2);
    cpu_read_check(16'h8000 + offs[4], "after_reset_bit");

    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        cpu_write(16'hE000, $urandom_range(0, 1), 1);
        cpu_write(16'h8000, 16'h80 | $urandom_range(0, 127), 1);
      end
      serial_write(0, $urandom_range(0, 31));
      serial_write(3, $urandom_range(0, 31));
      serial_write(1, $urandom_range(0, 31));
      serial_write(2, $urandom_range(0, 31));
      for (int r = 0; r < 3; r++)
        cpu_read_check($urandom_range(0, 1) * 16384 + offs[$urandom_range(0, 5)], "rand_prg");
      if ($urandom_range(0, 1) == 1) ppu_write($urandom_range(0, 8191), $urandom_range(0, 255));
      for (int r = 0; r < 2; r++) ppu_read_check($urandom_range(0, 16383), "rand_chr");
    end

    serial_write(0, 5'b10000);
    serial_write(1, 0);
    serial_write(2, 1);
    ppu_write(14'h0005, 8'h55);
    ppu_write(14'h1005, 8'hAA);
    ppu_read_check(14'h0005, "chr_bank0");
    check("chr_bank0_not_aa", (int'(chr_d_out) != 8'hAA) ? 1 : 0, 1);
    ppu_read_check(14'h1005, "chr_bank1");
    ppu_read_check(14'h2000, "chr_nt");

    // back-to-back strobes with a single idle cycle between them
    cpu_write(16'h8000, 16'h80, 1);
    serial_write(3, 0);
    prg_a_in = 15'h6000; prg_d_in = 8'h01;
    prg_nce_in = 1'b0; prg_r_nw_in = 1'b0; step();
    prg_nce_in = 1'b1; prg_r_nw_in = 1'b1; step();
    prg_nce_in = 1'b0; prg_r_nw_in = 1'b0; step();
    prg_nce_in = 1'b1; prg_r_nw_in = 1'b1; step(); step();
    model_serial(3, 1);
`ifndef CART_MMC1_WRITE_FILTER_EN
    model_serial(3, 1);
`endif
    cpu_write(16'hE000, 1, 1);
    cpu_write(16'hE000, 0, 1);
    cpu_write(16'hE000, 0, 1);
`ifdef CART_MMC1_WRITE_FILTER_EN
    check("filter_prg", m_prg, 0);
`else
    check("filter_prg", m_prg, 7);
`endif
    cpu_read_check(16'h8000, "filter_read");
    cpu_write(16'hE000, 0, 1);
    cpu_read_check(16'h8000 + offs[5], "filter_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
